// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: opcodes, write modes, FSM states
// and the latched request payload.
package mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned MEMW_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_LW  = 3'b000;
  localparam logic [OP_W-1:0] OP_LB  = 3'b001;
  localparam logic [OP_W-1:0] OP_LBU = 3'b010;
  localparam logic [OP_W-1:0] OP_SW  = 3'b100;
  localparam logic [OP_W-1:0] OP_SB  = 3'b101;

  localparam logic [MEMW_W-1:0] MEMW_NONE = 2'b00;
  localparam logic [MEMW_W-1:0] MEMW_BYTE = 2'b01;
  localparam logic [MEMW_W-1:0] MEMW_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_SW) || (op == OP_SB);
  endfunction

  // Write strobe a legal op issues on its final access cycle; loads issue none.
  function automatic logic [MEMW_W-1:0] op_memw(input logic [OP_W-1:0] op);
    logic [MEMW_W-1:0] w;
    w = MEMW_NONE;
    if (op == OP_SW) w = MEMW_WORD;
    else if (op == OP_SB) w = MEMW_BYTE;
    return w;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatter: picks the word or sign/zero-extends the byte;
// non-load opcodes yield zero.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = '0;
    case (op_i)
      OP_LW:   ext_c = word_i;
      OP_LB:   ext_c = {{8{byte_i[7]}}, byte_i};
      OP_LBU:  ext_c = {8'h00, byte_i};
      default: ext_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store initiator between execute and a 16-bit data
// memory, with optional settle cycles before the final access.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata_w,
  output logic [BYTE_W-1:0] mem_wdata_b,
  output logic [MEMW_W-1:0] mem_we,
  input  logic [DATA_W-1:0] mem_rword,
  input  logic [BYTE_W-1:0] mem_rbyte
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [MEMW_W-1:0] mem_we_q, mem_we_d;

  logic [DATA_W-1:0] load_c;
  logic              addr_oob_c;

  mem_load_ext u_load_ext (
    .op_i   (req_q.op),
    .word_i (mem_rword),
    .byte_i (mem_rbyte),
    .ext_c  (load_c)
  );

  assign addr_oob_c = (32'(req_addr) >= MEM_DEPTH);

  // State and output registers; reset also drops an in-flight write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= MEMW_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // The write strobe is registered, so it is armed on the edge that enters
  // the final access cycle (counter about to read zero).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_we_d    = MEMW_NONE;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d.op    = req_op;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_ready_d = 1'b0;
          rsp_data_d  = '0;
          if (!op_legal(req_op) || addr_oob_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ACCESS;
            cnt_d     = CNT_W'(WAIT_CYC);
            rsp_err_d = 1'b0;
            if (WAIT_CYC == 0) mem_we_d = op_memw(req_op);
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) mem_we_d = op_memw(req_q.op);
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = load_c;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = req_q.addr;
  assign mem_wdata_w = req_q.wdata;
  assign mem_wdata_b = req_q.wdata[BYTE_W-1:0];

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: one instance with no wait states, one with
// three, each attached to a small behavioural memory.
module tb_mem_lsu;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  // Instance A: WAIT_CYC = 0
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [2:0]  a_req_op;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_data, a_mem_addr, a_mem_wdata_w, a_rword;
  logic [7:0]  a_mem_wdata_b, a_rbyte;
  logic [1:0]  a_mem_we;
  logic [15:0] a_mem [16];

  // Instance B: WAIT_CYC = 3
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0]  b_req_op;
  logic [15:0] b_req_addr, b_req_wdata, b_rsp_data, b_mem_addr, b_mem_wdata_w, b_rword;
  logic [7:0]  b_mem_wdata_b, b_rbyte;
  logic [1:0]  b_mem_we;
  logic [15:0] b_mem [16];

  mem_lsu #(.MEM_DEPTH(16), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
    .mem_addr(a_mem_addr), .mem_wdata_w(a_mem_wdata_w), .mem_wdata_b(a_mem_wdata_b),
    .mem_we(a_mem_we), .mem_rword(a_rword), .mem_rbyte(a_rbyte)
  );

  mem_lsu #(.MEM_DEPTH(16), .WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .mem_addr(b_mem_addr), .mem_wdata_w(b_mem_wdata_w), .mem_wdata_b(b_mem_wdata_b),
    .mem_we(b_mem_we), .mem_rword(b_rword), .mem_rbyte(b_rbyte)
  );

  // Behavioural memories: combinational read, write at the clock edge.
  assign a_rword = a_mem[a_mem_addr[3:0]];
  assign a_rbyte = a_rword[7:0];
  assign b_rword = b_mem[b_mem_addr[3:0]];
  assign b_rbyte = b_rword[7:0];

  always @(posedge clk) begin
    if (a_mem_we == 2'b10) a_mem[a_mem_addr[3:0]] <= a_mem_wdata_w;
    else if (a_mem_we == 2'b01) a_mem[a_mem_addr[3:0]][7:0] <= a_mem_wdata_b;
    if (b_mem_we == 2'b10) b_mem[b_mem_addr[3:0]] <= b_mem_wdata_w;
    else if (b_mem_we == 2'b01) b_mem[b_mem_addr[3:0]][7:0] <= b_mem_wdata_b;
  end

  int          a_we_cnt = 0;
  int          b_we_cnt = 0;
  logic [15:0] a_we_last = '0;
  always @(negedge clk) begin
    if (a_mem_we != 2'b00) begin
      a_we_cnt++;
      a_we_last = a_mem_addr;
    end
    if (b_mem_we != 2'b00) b_we_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitors: every handshake pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && a_rsp_valid && a_rsp_ready) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_rsp: got data %h err %b with no request pending", a_rsp_data, a_rsp_err);
      end else begin
        e = a_q.pop_front();
        check("a_rsp_data", 32'(a_rsp_data), 32'(e.data));
        check("a_rsp_err", 32'(a_rsp_err), 32'(e.err));
      end
    end
    if (rst && b_rsp_valid && b_rsp_ready) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_rsp: got data %h err %b with no request pending", b_rsp_data, b_rsp_err);
      end else begin
        e = b_q.pop_front();
        check("b_rsp_data", 32'(b_rsp_data), 32'(e.data));
        check("b_rsp_err", 32'(b_rsp_err), 32'(e.err));
      end
    end
  end

  task automatic push_a(input logic [15:0] d, input logic er);
    exp_t e;
    e.data = d;
    e.err  = er;
    a_q.push_back(e);
  endtask

  // Issue on A once it is ready; returns the accepting edge time.
  task automatic send_a(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        output time t);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL a_req_ready_timeout: got req_ready 0 expected 1 within 100 cycles");
    end
    a_req_valid = 1'b1;
    a_req_op    = op;
    a_req_addr  = addr;
    a_req_wdata = wd;
    @(posedge clk);
    t = $time;
    #1;
    a_req_valid = 1'b0;
    a_req_op    = 3'b111;
    a_req_addr  = 16'hFFFF;
    a_req_wdata = 16'h0000;
  endtask

  task automatic drain_a();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_q.size() == 0 && !a_rsp_valid) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL a_drain_timeout: got %0d pending expected 0", a_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1, t2, t3;
    int  we0;
    bit  saw_valid;
    exp_t e;

    a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_op = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    a_mem[5] = 16'h1280;
    a_mem[9] = 16'hAAAA;
    b_mem[2] = 16'h4321;

    #12;
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(a_rsp_data), 32'd0);
    check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    check("rst_wdata_w", 32'(a_mem_wdata_w), 32'd0);
    check("rst_wdata_b", 32'(a_mem_wdata_b), 32'd0);
    check("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // SW then LW to the same word
    we0 = a_we_cnt;
    push_a(16'h0000, 1'b0);
    send_a(OP_SW, 16'd3, 16'hBEEF, t0);
    @(negedge clk);
    check("sw_mem_we", 32'(a_mem_we), 32'h2);
    check("sw_mem_addr", 32'(a_mem_addr), 32'd3);
    drain_a();
    check("sw_we_cycles", 32'(a_we_cnt - we0), 32'd1);
    check("sw_we_addr", 32'(a_we_last), 32'd3);
    check("sw_mem_content", 32'(a_mem[3]), 32'hBEEF);
    push_a(16'hBEEF, 1'b0);
    send_a(OP_LW, 16'd3, 16'h0000, t0);

    // Byte loads, byte store, word reload
    push_a(16'hFF80, 1'b0);
    send_a(OP_LB, 16'd5, 16'h0000, t0);
    push_a(16'h0080, 1'b0);
    send_a(OP_LBU, 16'd5, 16'h0000, t0);
    push_a(16'h0000, 1'b0);
    send_a(OP_SB, 16'd5, 16'h337F, t0);
    push_a(16'h127F, 1'b0);
    send_a(OP_LW, 16'd5, 16'h0000, t0);
    drain_a();

    // Error requests: out-of-range address and illegal opcode
    we0 = a_we_cnt;
    push_a(16'h0000, 1'b1);
    send_a(OP_LW, 16'd16, 16'h0000, t0);
    check("err_addr_valid_next_edge", 32'(a_rsp_valid), 32'd1);
    push_a(16'h0000, 1'b1);
    send_a(3'b011, 16'd2, 16'h0000, t0);
    check("err_op_valid_next_edge", 32'(a_rsp_valid), 32'd1);
    push_a(16'h0000, 1'b1);
    send_a(OP_SW, 16'h8000, 16'h1111, t0);
    drain_a();
    check("err_no_write", 32'(a_we_cnt - we0), 32'd0);

    // Back-to-back throughput and ordering
    push_a(16'hBEEF, 1'b0);
    send_a(OP_LW, 16'd3, 16'h0000, t0);
    push_a(16'h007F, 1'b0);
    send_a(OP_LBU, 16'd5, 16'h0000, t1);
    push_a(16'h0000, 1'b0);
    send_a(OP_SW, 16'd7, 16'h1234, t2);
    push_a(16'h1234, 1'b0);
    send_a(OP_LW, 16'd7, 16'h0000, t3);
    drain_a();
    check("b2b_gap1", 32'(t1 - t0), 32'd30);
    check("b2b_gap2", 32'(t2 - t1), 32'd30);
    check("b2b_gap3", 32'(t3 - t2), 32'd30);

    // Wait-state instance with a stalled consumer
    e.data = 16'h4321;
    e.err  = 1'b0;
    b_q.push_back(e);
    @(negedge clk);
    check("b_req_ready_idle", 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1; b_req_op = OP_LW; b_req_addr = 16'd2;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0; b_req_op = OP_SW; b_req_addr = 16'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_wait_rsp_valid", 32'(b_rsp_valid), (k == 4) ? 32'd1 : 32'd0);
      check("b_wait_req_ready", 32'(b_req_ready), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_stall_rsp_valid", 32'(b_rsp_valid), 32'd1);
      check("b_stall_rsp_data", 32'(b_rsp_data), 32'h4321);
      check("b_stall_req_ready", 32'(b_req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_q.size() == 0 && !b_rsp_valid) break;
    end
    check("b_drained", 32'(b_q.size()), 32'd0);
    check("b_no_write", 32'(b_we_cnt), 32'd0);
    @(negedge clk);
    check("b_req_ready_after", 32'(b_req_ready), 32'd1);

    // Reset during the access cycle of a store
    send_a(OP_SW, 16'd9, 16'h5555, t0);
    check("rst_sw_we_armed", 32'(a_mem_we), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("rst_sw_we_dropped", 32'(a_mem_we), 32'd0);
    check("rst_sw_req_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_rsp_valid) saw_valid = 1'b1;
    end
    check("rst_sw_no_rsp", 32'(saw_valid), 32'd0);
    check("rst_sw_mem_unchanged", 32'(a_mem[9]), 32'hAAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
